// File: rtl/child_genome_assembler.sv
// child_genome_assembler
//   Turns the 2-bit crossover select stream into child genome writes.
//   Code 10 copies gene[idx] from parent 1, 11 copies it from parent 2.
//   Code 00 does nothing, and code 01 ends the stream and reports the child size.
//   Parent reads are issued in the accept cycle. The child write follows one cycle later.
//   Optional feature macro: CROSSOVER_CNT_EN enables the per-parent gene counters
//   p1_cnt and p2_cnt. When it is undefined, both outputs read as zero.
module child_genome_assembler #(
  parameter int GENE_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] genome1_size,
  input  logic [ADDR_W-1:0] genome2_size,
  input  logic              sel_valid,
  input  logic [1:0]        sel,
  output logic              sel_ready,
  output logic              p1_rd_en,
  output logic [ADDR_W-1:0] p1_addr,
  input  logic [GENE_W-1:0] p1_data,
  output logic              p2_rd_en,
  output logic [ADDR_W-1:0] p2_addr,
  input  logic [GENE_W-1:0] p2_data,
  output logic              child_we,
  output logic [ADDR_W-1:0] child_addr,
  output logic [GENE_W-1:0] child_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] child_size,
  output logic              err,
  output logic [ADDR_W-1:0] p1_cnt,
  output logic [ADDR_W-1:0] p2_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  logic              sel_ready_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic              child_we_r;
  logic              pend_src_r;   // 0: parent 1, 1: parent 2
  logic              pend_zero_r;  // out-of-range gene, write zeros
  logic [ADDR_W-1:0] idx_r;
  logic [ADDR_W-1:0] g1_size_r;
  logic [ADDR_W-1:0] g2_size_r;
  logic [ADDR_W-1:0] child_addr_r;
  logic [ADDR_W-1:0] child_size_r;

  logic              accept_s;
  logic              take_s;
  logic              src_s;
  logic              ovf_s;
  logic              oor_s;
  logic              rd_s;
  logic [GENE_W-1:0] child_data_s;

  // Decode the accepted select code into take, overflow, out-of-range and read qualifiers.
  always_comb begin
    accept_s = rst & sel_valid & sel_ready_r;
    take_s   = accept_s & sel[1];
    src_s    = sel[0];
    ovf_s    = take_s & (idx_r == {ADDR_W{1'b1}});
    oor_s    = 1'b0;
    if (take_s && !ovf_s) begin
      if (src_s) begin
        oor_s = (idx_r >= g2_size_r);
      end else begin
        oor_s = (idx_r >= g1_size_r);
      end
    end else begin
      oor_s = 1'b0;
    end
    rd_s = take_s & ~ovf_s & ~oor_s;
  end

  assign p1_rd_en = rd_s & ~src_s;
  assign p2_rd_en = rd_s & src_s;
  assign p1_addr  = (rd_s & ~src_s) ? idx_r : {ADDR_W{1'b0}};
  assign p2_addr  = (rd_s & src_s) ? idx_r : {ADDR_W{1'b0}};

  // Select the returning parent word for the pending write, or zeros for out-of-range genes.
  always_comb begin
    child_data_s = {GENE_W{1'b0}};
    if (child_we_r && !pend_zero_r) begin
      if (pend_src_r) begin
        child_data_s = p2_data;
      end else begin
        child_data_s = p1_data;
      end
    end else begin
      child_data_s = {GENE_W{1'b0}};
    end
  end

  assign child_data = child_data_s;
  assign child_we   = child_we_r;
  assign child_addr = child_addr_r;
  assign sel_ready  = sel_ready_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign child_size = child_size_r;

  // Control FSM, gene index, write pipeline stage and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      sel_ready_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      child_we_r   <= 1'b0;
      pend_src_r   <= 1'b0;
      pend_zero_r  <= 1'b0;
      idx_r        <= {ADDR_W{1'b0}};
      g1_size_r    <= {ADDR_W{1'b0}};
      g2_size_r    <= {ADDR_W{1'b0}};
      child_addr_r <= {ADDR_W{1'b0}};
      child_size_r <= {ADDR_W{1'b0}};
    end else begin
      // The write stage fires for every accepted take code that is not dropped by overflow.
      child_we_r   <= take_s & ~ovf_s;
      child_addr_r <= (take_s & ~ovf_s) ? idx_r : {ADDR_W{1'b0}};
      pend_src_r   <= src_s;
      pend_zero_r  <= oor_s;
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r     <= RUN;
            sel_ready_r <= 1'b1;
            busy_r      <= 1'b1;
            err_r       <= 1'b0;
            idx_r       <= {ADDR_W{1'b0}};
            g1_size_r   <= genome1_size;
            g2_size_r   <= genome2_size;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (accept_s) begin
            case (sel)
              2'b10, 2'b11: begin
                if (ovf_s) begin
                  err_r <= 1'b1;
                end else begin
                  idx_r <= idx_r + ADDR_W'(1);
                  if (oor_s) begin
                    err_r <= 1'b1;
                  end else begin
                    err_r <= err_r;
                  end
                end
              end
              2'b01: begin
                state_r     <= DRAIN;
                sel_ready_r <= 1'b0;
              end
              default: begin
                idx_r <= idx_r;
              end
            endcase
          end else begin
            state_r <= RUN;
          end
        end
        DRAIN: begin
          state_r      <= DONE;
          done_r       <= 1'b1;
          child_size_r <= idx_r;
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          sel_ready_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

`ifdef CROSSOVER_CNT_EN
  logic [ADDR_W-1:0] p1_cnt_r;
  logic [ADDR_W-1:0] p2_cnt_r;

  // Count the genes actually copied from each parent. The counts clear on start and hold afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      p1_cnt_r <= {ADDR_W{1'b0}};
      p2_cnt_r <= {ADDR_W{1'b0}};
    end else if (state_r == IDLE && start) begin
      p1_cnt_r <= {ADDR_W{1'b0}};
      p2_cnt_r <= {ADDR_W{1'b0}};
    end else if (rd_s) begin
      if (src_s) begin
        p2_cnt_r <= p2_cnt_r + ADDR_W'(1);
      end else begin
        p1_cnt_r <= p1_cnt_r + ADDR_W'(1);
      end
    end else begin
      p1_cnt_r <= p1_cnt_r;
      p2_cnt_r <= p2_cnt_r;
    end
  end

  assign p1_cnt = p1_cnt_r;
  assign p2_cnt = p2_cnt_r;
`else
  assign p1_cnt = {ADDR_W{1'b0}};
  assign p2_cnt = {ADDR_W{1'b0}};
`endif

endmodule

// File: tb/tb_child_genome_assembler.sv
// Directed bench for child_genome_assembler. It models the parent memories with a 1-cycle read
// latency, captures child writes, and checks them against hand-computed values.
module tb_child_genome_assembler;

  localparam int GENE_W = 32;
  localparam int ADDR_W = 8;
`ifdef CROSSOVER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] genome1_size;
  logic [ADDR_W-1:0] genome2_size;
  logic              sel_valid;
  logic [1:0]        sel;
  logic              sel_ready;
  logic              p1_rd_en;
  logic [ADDR_W-1:0] p1_addr;
  logic [GENE_W-1:0] p1_data;
  logic              p2_rd_en;
  logic [ADDR_W-1:0] p2_addr;
  logic [GENE_W-1:0] p2_data;
  logic              child_we;
  logic [ADDR_W-1:0] child_addr;
  logic [GENE_W-1:0] child_data;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] child_size;
  logic              err;
  logic [ADDR_W-1:0] p1_cnt;
  logic [ADDR_W-1:0] p2_cnt;

  child_genome_assembler #(.GENE_W(GENE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .genome1_size(genome1_size), .genome2_size(genome2_size),
    .sel_valid(sel_valid), .sel(sel), .sel_ready(sel_ready),
    .p1_rd_en(p1_rd_en), .p1_addr(p1_addr), .p1_data(p1_data),
    .p2_rd_en(p2_rd_en), .p2_addr(p2_addr), .p2_data(p2_data),
    .child_we(child_we), .child_addr(child_addr), .child_data(child_data),
    .busy(busy), .done(done), .child_size(child_size), .err(err),
    .p1_cnt(p1_cnt), .p2_cnt(p2_cnt)
  );

  always #5 clk = ~clk;

  logic [GENE_W-1:0] mem1 [0:255];
  logic [GENE_W-1:0] mem2 [0:255];
  logic [GENE_W-1:0] child_mem [0:255];
  int                wr_time [0:255];
  logic [GENE_W-1:0] p1_q = '0;
  logic [GENE_W-1:0] p2_q = '0;
  int                cyc = 0;
  int                wr_total = 0;
  int                p1_reads = 0;
  int                stray = 0;
  logic              gap_mon = 1'b0;

  assign p1_data = p1_q;
  assign p2_data = p2_q;

  // Parent memories with one cycle of read latency, plus the child write and strobe monitors.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (p1_rd_en) begin
      p1_q     <= mem1[p1_addr];
      p1_reads <= p1_reads + 1;
    end
    if (p2_rd_en) p2_q <= mem2[p2_addr];
    if (child_we) begin
      child_mem[child_addr] <= child_data;
      wr_time[child_addr]   <= cyc;
      wr_total              <= wr_total + 1;
    end
    if (gap_mon && (p1_rd_en || p2_rd_en || child_we)) stray <= stray + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] seq [0:299];

  task automatic begin_run(input int g1, input int g2);
    genome1_size = ADDR_W'(g1);
    genome2_size = ADDR_W'(g2);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic play(input int n);
    for (int i = 0; i < n; i++) begin
      sel_valid = 1'b1;
      sel       = seq[i];
      tick();
    end
    sel_valid = 1'b0;
    sel       = 2'b00;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check_eq({tag, "_done_seen"}, 64'(seen), 64'(1));
  endtask

  int wr0;
  int rd0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 32'hA000_0000 + 32'(i);
      mem2[i] = 32'hB000_0000 + 32'(i);
    end
    rst = 1'b0; start = 1'b0; sel_valid = 1'b0; sel = 2'b00;
    genome1_size = '0; genome2_size = '0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();

    // Reset state
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_ready", 64'(sel_ready), 64'(0));
    check_eq("rst_size", 64'(child_size), 64'(0));
    check_eq("rst_we", 64'(child_we), 64'(0));

    // A: sizes 6/6, stream 10 x3, 11 x3, 01 back-to-back
    begin_run(6, 6);
    check_eq("A_busy", 64'(busy), 64'(1));
    check_eq("A_ready", 64'(sel_ready), 64'(1));
    wr0 = wr_total;
    seq[0] = 2'b10; seq[1] = 2'b10; seq[2] = 2'b10;
    seq[3] = 2'b11; seq[4] = 2'b11; seq[5] = 2'b11; seq[6] = 2'b01;
    play(7);
    wait_done("A");
    check_eq("A_size", 64'(child_size), 64'(6));
    check_eq("A_err", 64'(err), 64'(0));
    check_eq("A_writes", 64'(wr_total - wr0), 64'(6));
    check_eq("A_c0", 64'(child_mem[0]), 64'(32'hA000_0000));
    check_eq("A_c2", 64'(child_mem[2]), 64'(32'hA000_0002));
    check_eq("A_c3", 64'(child_mem[3]), 64'(32'hB000_0003));
    check_eq("A_c5", 64'(child_mem[5]), 64'(32'hB000_0005));
    check_eq("A_rate", 64'(wr_time[5] - wr_time[0]), 64'(5));
    tick();
    check_eq("A_busy_off", 64'(busy), 64'(0));
    check_eq("A_done_off", 64'(done), 64'(0));

    // Reset during RUN, asserted together with an accepted take code
    begin_run(6, 6);
    seq[0] = 2'b10; seq[1] = 2'b11;
    play(2);
    sel_valid = 1'b1; sel = 2'b10; rst = 1'b0;
    #1;
    check_eq("R_rd_gated", 64'(p1_rd_en), 64'(0));
    tick();
    check_eq("R_we0", 64'(child_we), 64'(0));
    tick();
    check_eq("R_busy", 64'(busy), 64'(0));
    check_eq("R_ready", 64'(sel_ready), 64'(0));
    check_eq("R_size", 64'(child_size), 64'(0));
    check_eq("R_we1", 64'(child_we), 64'(0));
    rst = 1'b1; sel_valid = 1'b0; sel = 2'b00;
    tick();
    check_eq("R_we2", 64'(child_we), 64'(0));
    check_eq("R_idle", 64'(sel_ready), 64'(0));

    // B: sizes 4/8, 10 x5 -> the fifth gene is out of range
    begin_run(4, 8);
    wr0 = wr_total; rd0 = p1_reads;
    for (int i = 0; i < 5; i++) seq[i] = 2'b10;
    seq[5] = 2'b01;
    play(6);
    wait_done("B");
    check_eq("B_size", 64'(child_size), 64'(5));
    check_eq("B_err", 64'(err), 64'(1));
    check_eq("B_c3", 64'(child_mem[3]), 64'(32'hA000_0003));
    check_eq("B_c4_zero", 64'(child_mem[4]), 64'(0));
    check_eq("B_writes", 64'(wr_total - wr0), 64'(5));
    check_eq("B_reads", 64'(p1_reads - rd0), 64'(4));
    check_eq("B_p1cnt", 64'(p1_cnt), CNT_EN ? 64'(4) : 64'(0));
    tick();

    // C: 10, 00, three cycles with valid low, 11, 01
    begin_run(6, 6);
    wr0 = wr_total;
    check_eq("C_err_clr", 64'(err), 64'(0));
    seq[0] = 2'b10; seq[1] = 2'b00;
    play(2);
    gap_mon = 1'b1;
    tick(); tick(); tick();
    gap_mon = 1'b0;
    seq[0] = 2'b11; seq[1] = 2'b01;
    play(2);
    wait_done("C");
    check_eq("C_size", 64'(child_size), 64'(2));
    check_eq("C_stray", 64'(stray), 64'(0));
    check_eq("C_writes", 64'(wr_total - wr0), 64'(2));
    check_eq("C_c0", 64'(child_mem[0]), 64'(32'hA000_0000));
    check_eq("C_c1", 64'(child_mem[1]), 64'(32'hB000_0001));
    tick();

    // D: a start pulse while busy must not resample sizes or clear idx
    begin_run(3, 3);
    seq[0] = 2'b10;
    play(1);
    genome1_size = 8'd9; genome2_size = 8'd9; start = 1'b1;
    tick();
    start = 1'b0;
    seq[0] = 2'b10; seq[1] = 2'b10; seq[2] = 2'b10; seq[3] = 2'b01;
    play(4);
    wait_done("D");
    check_eq("D_size", 64'(child_size), 64'(4));
    check_eq("D_err", 64'(err), 64'(1));
    tick();

    // E: sizes 10/10, 10 x3, 11 x7
    begin_run(10, 10);
    for (int i = 0; i < 3; i++) seq[i] = 2'b10;
    for (int i = 3; i < 10; i++) seq[i] = 2'b11;
    seq[10] = 2'b01;
    play(11);
    wait_done("E");
    check_eq("E_size", 64'(child_size), 64'(10));
    check_eq("E_c2", 64'(child_mem[2]), 64'(32'hA000_0002));
    check_eq("E_c9", 64'(child_mem[9]), 64'(32'hB000_0009));
    check_eq("E_p1cnt", 64'(p1_cnt), CNT_EN ? 64'(3) : 64'(0));
    check_eq("E_p2cnt", 64'(p2_cnt), CNT_EN ? 64'(7) : 64'(0));
    tick();
    tick();
    check_eq("E_p2cnt_hold", 64'(p2_cnt), CNT_EN ? 64'(7) : 64'(0));

    // F: overflow, 256 takes with sizes 255/255; the last take is dropped
    begin_run(255, 255);
    wr0 = wr_total; rd0 = p1_reads;
    for (int i = 0; i < 256; i++) seq[i] = 2'b10;
    seq[256] = 2'b01;
    play(257);
    wait_done("F");
    check_eq("F_size", 64'(child_size), 64'(255));
    check_eq("F_err", 64'(err), 64'(1));
    check_eq("F_writes", 64'(wr_total - wr0), 64'(255));
    check_eq("F_reads", 64'(p1_reads - rd0), 64'(255));
    check_eq("F_c254", 64'(child_mem[254]), 64'(32'hA000_00FE));
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
